fp_axis_operand_master: RTL and testbench

//  AXI-stream initiator that feeds operand pairs to the fp32 adder/multiplier IP cores and collects their results.
//  - A loader pushes (a,b) pairs into a local FIFO.
//  - The block drives the IP's A and B slave channels with tlast framing per kernel burst.
//  - Results return through a one-entry output register with valid/ack.
//  - Sits between the conv-layer operand fetch and the floating_mult/floating_adder instances.

---
 rtl/fp_axis_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/fp_axis_operand_master.sv | 168 ++++++++++++++++
 tb/tb_fp_axis_operand_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_axis_pkg.sv
// Shared types for the fp32 operand streaming slice.
//   FP32_W          fp32 bit-pattern width
//   fp32_t          one fp32 operand/result (raw bits, never interpreted)
//   operand_pair_t  {a,b} pair as queued toward the adder/multiplier IP
//   issue_state_t   operand issue FSM states
package fp_axis_pkg;

  localparam int unsigned FP32_W = 32;

  typedef logic [FP32_W-1:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } operand_pair_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, rst_n        clock, synchronous active-low reset (pointers/count only)
//   wr_en, wr_data    push; ignored while full, even if a pop happens that cycle
//   rd_en, rd_data    pop; rd_data always shows the current head entry
//   full, empty       status
//   count             occupancy 0..DEPTH
module sync_fifo #(
  parameter int unsigned W      = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    end
  end

  // Storage carries no reset; contents are only visible once counted valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_axis_operand_master.sv
// AXI-stream initiator feeding (a,b) operand pairs to the fp32 adder/multiplier
// IP and collecting its results.
//   op_wr_en/op_a/op_b            push a pair into the operand FIFO
//   op_full/op_count              FIFO status
//   m_axis_a_*/m_axis_b_*         operand streams, tlast every BURST_LEN pairs
//   s_axis_result_*               result stream from the IP
//   res_valid/res_data/res_last   one-entry result register, freed by res_ack
//   outstanding                   pairs issued but not yet returned
//   err_tlast                     sticky result framing / underflow error
module fp_axis_operand_master
  import fp_axis_pkg::*;
#(
  parameter int unsigned DATA_W    = FP32_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned BURST_LEN = 9,
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_wr_en,
  input  logic [DATA_W-1:0]            op_a,
  input  logic [DATA_W-1:0]            op_b,
  output logic                         op_full,
  output logic [ADDR_W:0]              op_count,
  output logic                         m_axis_a_tvalid,
  input  logic                         m_axis_a_tready,
  output logic [DATA_W-1:0]            m_axis_a_tdata,
  output logic                         m_axis_a_tlast,
  output logic                         m_axis_b_tvalid,
  input  logic                         m_axis_b_tready,
  output logic [DATA_W-1:0]            m_axis_b_tdata,
  output logic                         m_axis_b_tlast,
  input  logic                         s_axis_result_tvalid,
  output logic                         s_axis_result_tready,
  input  logic [DATA_W-1:0]            s_axis_result_tdata,
  input  logic                         s_axis_result_tlast,
  output logic                         res_valid,
  output logic [DATA_W-1:0]            res_data,
  output logic                         res_last,
  input  logic                         res_ack,
  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err_tlast
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTST) + 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  issue_state_t         state;
  issue_state_t         state_next;
  logic [2*DATA_W-1:0]  head;
  logic                 fifo_empty;
  logic                 done_a;
  logic                 done_b;
  logic                 hs_a;
  logic                 hs_b;
  logic                 pair_done;
  logic                 more_ready;
  logic                 capture;
  logic                 dec;
  logic [OUT_W-1:0]     out_next;
  logic [BEAT_W-1:0]    beat;
  logic [BEAT_W-1:0]    rcount;

  sync_fifo #(
    .W      (2 * DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (op_wr_en),
    .wr_data ({op_a, op_b}),
    .rd_en   (pair_done),
    .rd_data (head),
    .full    (op_full),
    .empty   (fifo_empty),
    .count   (op_count)
  );

  assign hs_a      = m_axis_a_tvalid && m_axis_a_tready;
  assign hs_b      = m_axis_b_tvalid && m_axis_b_tready;
  assign pair_done = (state == SEND) && (done_a || hs_a) && (done_b || hs_b);

  assign s_axis_result_tready = !res_valid || res_ack;
  assign capture  = s_axis_result_tvalid && s_axis_result_tready;
  // A stray result with nothing in flight must not wrap the counter.
  assign dec      = capture && (outstanding != '0);
  assign out_next = outstanding + OUT_W'(pair_done) - OUT_W'(dec);

  // Stay in SEND without a bubble only if a pair remains after this pop.
  assign more_ready = (op_count > (ADDR_W+1)'(1)) && (out_next < OUT_W'(MAX_OUTST));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty && (outstanding < OUT_W'(MAX_OUTST))) state_next = SEND;
      SEND:    if (pair_done && !more_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head data is presented for the whole SEND phase, so a channel that
  // finished early keeps stable data while the other one is still waiting.
  always_comb begin
    m_axis_a_tvalid = 1'b0;
    m_axis_b_tvalid = 1'b0;
    m_axis_a_tdata  = '0;
    m_axis_b_tdata  = '0;
    m_axis_a_tlast  = 1'b0;
    m_axis_b_tlast  = 1'b0;
    if (state == SEND) begin
      m_axis_a_tvalid = !done_a;
      m_axis_b_tvalid = !done_b;
      m_axis_a_tdata  = head[2*DATA_W-1:DATA_W];
      m_axis_b_tdata  = head[DATA_W-1:0];
      m_axis_a_tlast  = (beat == LAST_BEAT);
      m_axis_b_tlast  = (beat == LAST_BEAT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      beat        <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (pair_done) begin
        done_a <= 1'b0;
        done_b <= 1'b0;
        beat   <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end else begin
        if (hs_a) done_a <= 1'b1;
        if (hs_b) done_b <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      rcount    <= '0;
      err_tlast <= 1'b0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= s_axis_result_tdata;
        res_last  <= s_axis_result_tlast;
        rcount    <= (rcount == LAST_BEAT) ? '0 : rcount + 1'b1;
        if ((outstanding == '0) || (s_axis_result_tlast != (rcount == LAST_BEAT)))
          err_tlast <= 1'b1;
      end else if (res_ack) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_axis_operand_master.sv
module tb_fp_axis_operand_master;
  import fp_axis_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BL    = 9;
  localparam int unsigned MO    = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_wr_en;
  logic [DW-1:0] op_a, op_b;
  logic          op_full;
  logic [3:0]    op_count;
  logic          a_tvalid, a_tready, a_tlast;
  logic [DW-1:0] a_tdata;
  logic          b_tvalid, b_tready, b_tlast;
  logic [DW-1:0] b_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          res_valid, res_last, res_ack;
  logic [DW-1:0] res_data;
  logic [4:0]    outstanding;
  logic          err_tlast;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  fp_axis_operand_master #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(3), .BURST_LEN(BL), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_wr_en(op_wr_en), .op_a(op_a), .op_b(op_b), .op_full(op_full), .op_count(op_count),
    .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready), .m_axis_a_tdata(a_tdata), .m_axis_a_tlast(a_tlast),
    .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready), .m_axis_b_tdata(b_tdata), .m_axis_b_tlast(b_tlast),
    .s_axis_result_tvalid(s_tvalid), .s_axis_result_tready(s_tready),
    .s_axis_result_tdata(s_tdata), .s_axis_result_tlast(s_tlast),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ack(res_ack),
    .outstanding(outstanding), .err_tlast(err_tlast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_wr_en = 1'b0; op_a = '0; op_b = '0;
    a_tready = 1'b0; b_tready = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    res_ack  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (op_count !== 4'd0) $display("FAIL reset_op_count got %0d exp 0", op_count); else n_pass++;
    n_checks++; if (op_full !== 1'b0) $display("FAIL reset_op_full got %b exp 0", op_full); else n_pass++;
    n_checks++; if ({a_tvalid, b_tvalid, a_tlast, b_tlast} !== 4'b0) $display("FAIL reset_axis_ctrl got %b exp 0000", {a_tvalid, b_tvalid, a_tlast, b_tlast}); else n_pass++;
    n_checks++; if (a_tdata !== '0 || b_tdata !== '0) $display("FAIL reset_tdata got %h/%h exp 0/0", a_tdata, b_tdata); else n_pass++;
    n_checks++; if ({res_valid, res_last} !== 2'b0 || res_data !== '0) $display("FAIL reset_res got v=%b l=%b d=%h exp 0", res_valid, res_last, res_data); else n_pass++;
    n_checks++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding got %0d exp 0", outstanding); else n_pass++;
    n_checks++; if (err_tlast !== 1'b0) $display("FAIL reset_err_tlast got %b exp 0", err_tlast); else n_pass++;
  endtask

  task automatic test_single_pair();
    do_reset();
    a_tready = 1'b1; b_tready = 1'b1;
    op_a = 32'h4020_0000; op_b = 32'h42C8_0000; op_wr_en = 1'b1;
    tick();
    op_wr_en = 1'b0;
    n_checks++; if (op_count !== 4'd1 || a_tvalid !== 1'b0) $display("FAIL single_after_push got cnt=%0d av=%b exp 1/0", op_count, a_tvalid); else n_pass++;
    tick();
    n_checks++; if (a_tvalid !== 1'b1 || b_tvalid !== 1'b1) $display("FAIL single_tvalid got %b%b exp 11", a_tvalid, b_tvalid); else n_pass++;
    n_checks++; if (a_tdata !== 32'h4020_0000 || b_tdata !== 32'h42C8_0000) $display("FAIL single_tdata got %h/%h exp 40200000/42c80000", a_tdata, b_tdata); else n_pass++;
    n_checks++; if (outstanding !== 5'd0) $display("FAIL single_out0 got %0d exp 0", outstanding); else n_pass++;
    tick();
    n_checks++; if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0) $display("FAIL single_one_hs got %b%b exp 00", a_tvalid, b_tvalid); else n_pass++;
    n_checks++; if (outstanding !== 5'd1 || op_count !== 4'd0) $display("FAIL single_out1 got out=%0d cnt=%0d exp 1/0", outstanding, op_count); else n_pass++;
    s_tvalid = 1'b1; s_tdata = 32'h437A_0000; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_data !== 32'h437A_0000) $display("FAIL single_result got v=%b d=%h exp 1/437a0000", res_valid, res_data); else n_pass++;
    n_checks++; if (outstanding !== 5'd0 || err_tlast !== 1'b0) $display("FAIL single_out_back got out=%0d err=%b exp 0/0", outstanding, err_tlast); else n_pass++;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_ack got %b exp 0", res_valid); else n_pass++;
  endtask

  task automatic test_skewed();
    logic [DW-1:0] a0, b0, a1, b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    do_reset();
    op_wr_en = 1'b1; op_a = a0; op_b = b0;
    tick();
    op_a = a1; op_b = b1;
    tick();
    op_wr_en = 1'b0;
    // cycle 1 of tvalid
    n_checks++; if (a_tvalid !== 1'b1 || b_tvalid !== 1'b1) $display("FAIL skew_start got %b%b exp 11", a_tvalid, b_tvalid); else n_pass++;
    tick();
    tick();
    a_tready = 1'b1;   // cycle 3
    tick();
    a_tready = 1'b0;
    n_checks++; if (a_tvalid !== 1'b0 || b_tvalid !== 1'b1) $display("FAIL skew_a_drop got %b%b exp 01", a_tvalid, b_tvalid); else n_pass++;
    n_checks++; if (b_tdata !== b0 || op_count !== 4'd2) $display("FAIL skew_b_hold got %h cnt=%0d exp %h cnt=2", b_tdata, op_count, b0); else n_pass++;
    tick();
    n_checks++; if (b_tdata !== b0 || a_tvalid !== 1'b0) $display("FAIL skew_b_stable got %h av=%b exp %h av=0", b_tdata, a_tvalid, b0); else n_pass++;
    tick();
    b_tready = 1'b1;   // cycle 6
    tick();
    b_tready = 1'b0;
    n_checks++; if (op_count !== 4'd1 || outstanding !== 5'd1) $display("FAIL skew_pop_once got cnt=%0d out=%0d exp 1/1", op_count, outstanding); else n_pass++;
    n_checks++; if (a_tvalid !== 1'b1 || b_tvalid !== 1'b1 || a_tdata !== a1 || b_tdata !== b1) $display("FAIL skew_next_pair got %b%b %h/%h exp 11 %h/%h", a_tvalid, b_tvalid, a_tdata, b_tdata, a1, b1); else n_pass++;
  endtask

  task automatic test_framing();
    operand_pair_t pend[$], mq[$], pr;
    res_t          ipq[$], rr;
    int unsigned   issued = 0, rcnt = 0, mout = 0, cyc = 0, tl_seen = 0;
    logic          mrv = 1'b0, mlast = 1'b0, merr = 1'b0, ma = 1'b0, mb = 1'b0;
    logic          push, cap, exp_last;
    logic [DW-1:0] mres = '0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      pr.a = $urandom; pr.b = $urandom;
      pend.push_back(pr);
    end
    while ((pend.size() > 0 || mq.size() > 0 || ipq.size() > 0 || mrv) && cyc < 4000) begin
      n_checks++; if (op_count !== 4'(mq.size()) || op_full !== (mq.size() == DEPTH)) $display("FAIL frame_count cyc%0d got %0d exp %0d", cyc, op_count, mq.size()); else n_pass++;
      n_checks++; if (outstanding !== 5'(mout)) $display("FAIL frame_outstanding cyc%0d got %0d exp %0d", cyc, outstanding, mout); else n_pass++;
      n_checks++; if (res_valid !== mrv || (mrv && (res_data !== mres || res_last !== mlast))) $display("FAIL frame_result cyc%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", cyc, res_valid, res_data, res_last, mrv, mres, mlast); else n_pass++;
      n_checks++; if (err_tlast !== merr) $display("FAIL frame_err cyc%0d got %b exp %b", cyc, err_tlast, merr); else n_pass++;
      push = (pend.size() > 0) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      op_wr_en = push;
      if (push) begin op_a = pend[0].a; op_b = pend[0].b; end
      a_tready = 1'($urandom_range(0, 1));
      b_tready = 1'($urandom_range(0, 1));
      res_ack  = ($urandom_range(0, 2) == 0);
      s_tvalid = (ipq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (ipq.size() > 0) begin s_tdata = ipq[0].d; s_tlast = ipq[0].l; end
      #1;
      n_checks++; if (s_tready !== (!mrv || res_ack)) $display("FAIL frame_s_tready cyc%0d got %b exp %b", cyc, s_tready, !mrv || res_ack); else n_pass++;
      exp_last = (issued % BL == BL - 1);
      if (ma && a_tvalid) begin n_checks++; $display("FAIL frame_a_redrive cyc%0d got tvalid=1 exp 0", cyc); end
      if (mb && b_tvalid) begin n_checks++; $display("FAIL frame_b_redrive cyc%0d got tvalid=1 exp 0", cyc); end
      if (a_tvalid && a_tready && !ma) begin
        n_checks++;
        if (mq.size() == 0 || a_tdata !== mq[0].a || a_tlast !== exp_last) $display("FAIL frame_a_beat%0d got %h l=%b exp l=%b", issued, a_tdata, a_tlast, exp_last); else n_pass++;
        if (a_tlast) tl_seen++;
        ma = 1'b1;
      end
      if (b_tvalid && b_tready && !mb) begin
        n_checks++;
        if (mq.size() == 0 || b_tdata !== mq[0].b || b_tlast !== exp_last) $display("FAIL frame_b_beat%0d got %h l=%b exp l=%b", issued, b_tdata, b_tlast, exp_last); else n_pass++;
        mb = 1'b1;
      end
      cap = s_tvalid && (!mrv || res_ack);
      if (cap) begin
        rr = ipq.pop_front();
        if (mout == 0 || rr.l != (rcnt % BL == BL - 1)) merr = 1'b1;
        rcnt++;
        mres = rr.d; mlast = rr.l; mrv = 1'b1;
        if (mout > 0) mout--;
      end else if (res_ack) begin
        mrv = 1'b0;
      end
      if (ma && mb && mq.size() > 0) begin
        pr = mq.pop_front();
        rr.d = pr.a + pr.b;
        rr.l = (issued % BL == BL - 1) || (issued == 23);   // beat 5 of third frame flagged last
        ipq.push_back(rr);
        issued++; mout++;
        ma = 1'b0; mb = 1'b0;
      end
      if (push) mq.push_back(pend.pop_front());
      tick();
      cyc++;
    end
    n_checks++; if (cyc >= 4000) $display("FAIL frame_timeout got issued=%0d exp 24", issued); else n_pass++;
    idle_inputs();
    n_checks++; if (tl_seen !== 2) $display("FAIL frame_tlast_count got %0d exp 2", tl_seen); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (err_tlast !== 1'b1) $display("FAIL frame_err_sticky got %b exp 1", err_tlast); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_tready = 1'b1; b_tready = 1'b1;
    op_wr_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_a = 32'(i); op_b = 32'(i + 100);
      tick();
    end
    n_checks++; if (outstanding !== 5'd16 || op_count !== 4'd8 || op_full !== 1'b1) $display("FAIL bp_saturate got out=%0d cnt=%0d full=%b exp 16/8/1", outstanding, op_count, op_full); else n_pass++;
    n_checks++; if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0) $display("FAIL bp_stall got %b%b exp 00", a_tvalid, b_tvalid); else n_pass++;
    op_a = 32'hDEAD_BEEF;
    tick();
    op_wr_en = 1'b0;
    n_checks++; if (op_count !== 4'd8) $display("FAIL bp_push_full got %0d exp 8", op_count); else n_pass++;
    s_tvalid = 1'b1; s_tdata = 32'h1111_1111; s_tlast = 1'b0;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 32'h1111_1111 || s_tready !== 1'b0) $display("FAIL bp_first_capture got v=%b d=%h rdy=%b exp 1/11111111/0", res_valid, res_data, s_tready); else n_pass++;
    n_checks++; if (outstanding !== 5'd15) $display("FAIL bp_dec got %0d exp 15", outstanding); else n_pass++;
    s_tdata = 32'h2222_2222;
    tick();
    n_checks++; if (a_tvalid !== 1'b1 || a_tdata !== 32'd16 || b_tdata !== 32'd116) $display("FAIL bp_reissue got v=%b %h/%h exp 1 10/74", a_tvalid, a_tdata, b_tdata); else n_pass++;
    tick();
    n_checks++; if (outstanding !== 5'd16 || op_count !== 4'd7 || res_data !== 32'h1111_1111) $display("FAIL bp_hold got out=%0d cnt=%0d d=%h exp 16/7/11111111", outstanding, op_count, res_data); else n_pass++;
    res_ack = 1'b1;
    #1;
    n_checks++; if (s_tready !== 1'b1) $display("FAIL bp_ack_ready got %b exp 1", s_tready); else n_pass++;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 32'h2222_2222 || outstanding !== 5'd15) $display("FAIL bp_ack_capture got v=%b d=%h out=%0d exp 1/22222222/15", res_valid, res_data, outstanding); else n_pass++;
    s_tvalid = 1'b0;
    tick();
    res_ack = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL bp_ack_clear got %b exp 0", res_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_a = $urandom; op_b = $urandom;
      tick();
    end
    op_wr_en = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'h3333_3333; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    n_checks++; if (err_tlast !== 1'b1 || outstanding !== 5'd0) $display("FAIL mid_underflow got err=%b out=%0d exp 1/0", err_tlast, outstanding); else n_pass++;
    n_checks++; if (op_count !== 4'd5 || a_tvalid !== 1'b1) $display("FAIL mid_queued got cnt=%0d av=%b exp 5/1", op_count, a_tvalid); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (op_count !== 4'd0 || a_tvalid !== 1'b0 || b_tvalid !== 1'b0) $display("FAIL mid_reset_fifo got cnt=%0d v=%b%b exp 0/00", op_count, a_tvalid, b_tvalid); else n_pass++;
    n_checks++; if (outstanding !== 5'd0 || err_tlast !== 1'b0 || res_valid !== 1'b0) $display("FAIL mid_reset_state got out=%0d err=%b rv=%b exp 0/0/0", outstanding, err_tlast, res_valid); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_pair();
    test_skewed();
    test_framing();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
